hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core. It sits beside the forwarding unit and covers the hazards that forwarding cannot resolve.
- Stalls the front end for load-use hazards. Flushes IF/ID and ID/EX on a taken branch resolved in EX.
- Freezes the pipeline while a multi-cycle multiply occupies EX.
- Keeps a saturating stall-cycle counter for performance checks.

Parameters:
- MUL_LATENCY, 4, total cycles a multiply occupies EX (legal 1..16).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- ID_EX_MemRead  input  1  instruction in EX is a load.
- ID_EX_RegisterRt  input  5  destination register of the load in EX.
- ID_EX_IsMul  input  1  instruction in EX is a multi-cycle multiply.
- IF_ID_RegisterRs  input  5  Rs source of the instruction in ID.
- IF_ID_RegisterRt  input  5  Rt source of the instruction in ID.
- EX_BranchTaken  input  1  branch in EX resolved taken this cycle.
- PCWrite  output  1  PC update enable.
- IF_ID_Write  output  1  IF/ID register load enable.
- ID_EX_Write  output  1  ID/EX register load enable.
- IF_ID_Flush  output  1  clear IF/ID to NOP.
- ID_EX_Bubble  output  1  zero ID/EX control fields (insert NOP).
- EX_MEM_Bubble  output  1  zero EX/MEM control fields.
- mul_start  output  1  one-cycle start pulse to the multiplier.
- mul_busy  output  1  high while in MUL_WAIT.
- stall_cycles  output  CNT_W  count of cycles with PCWrite=0, saturating.

Behaviour:
- State register: two states, RUN and MUL_WAIT. Down-counter cnt is 4 bits wide.
- Outputs are combinational from state, cnt and the inputs. Only state, cnt and stall_cycles are registered.
- Reset:
  - Next edge: state=RUN, cnt=0, stall_cycles=0.
  - While reset is high, outputs are forced to their idle values: PCWrite=IF_ID_Write=ID_EX_Write=1, every other 1-bit output=0.
  - Reset during MUL_WAIT abandons the multiply. No mul_start is reissued.
- Default (RUN, no event): all write enables =1, all flush/bubble/start outputs =0.
- Priority in RUN: EX_BranchTaken > ID_EX_IsMul > load-use.
  - A branch and a multiply cannot both be in EX. If both are asserted, the branch wins and the multiply is ignored.
- Taken branch (RUN):
  - IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1.
  - Any concurrent load-use stall is suppressed.
  - No state change.
- Load-use hazard: ID_EX_MemRead && ID_EX_RegisterRt!=0 && (ID_EX_RegisterRt==IF_ID_RegisterRs || ID_EX_RegisterRt==IF_ID_RegisterRt).
  - Response in RUN: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1.
  - Exactly one cycle per detected hazard. No state change.
- Multiply issue (RUN && ID_EX_IsMul && !EX_BranchTaken):
  - mul_start=1 for exactly this cycle.
  - If MUL_LATENCY==1: no stall, stay in RUN.
  - Else: PCWrite=IF_ID_Write=ID_EX_Write=0 and EX_MEM_Bubble=1. Next state=MUL_WAIT with cnt=MUL_LATENCY-2.
- MUL_WAIT:
  - mul_busy=1. ID_EX_IsMul and EX_BranchTaken are ignored.
  - cnt!=0: keep the full freeze, cnt decrements.
  - cnt==0: last cycle, multiply result valid. All enables =1, EX_MEM_Bubble=0. Next state=RUN.
- Stall length: a multiply freezes the front end for MUL_LATENCY-1 cycles and occupies EX for MUL_LATENCY cycles. A back-to-back multiply is detected fresh in the following RUN cycle.
- stall_cycles: increments on every non-reset cycle with PCWrite=0. It holds at 2^CNT_W-1 (no wrap).

Decomposition:
- Package pipe_ctrl_pkg: state enum {RUN, MUL_WAIT}, constant REG_ZERO=5'd0, width of cnt.
- Sub-module load_use_detect: purely combinational comparator producing the hazard bit.
- FSM, counter and output muxing stay in hazard_control_unit.

Test Plan:
- Load-use: MemRead=1, ID_EX_Rt=5, IF_ID_Rs=5 -> one cycle PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1; stall_cycles 0->1.
- Load to $0: MemRead=1, ID_EX_Rt=0, IF_ID_Rs=0 -> no stall, all enables 1.
- Branch plus load-use in the same cycle (EX_BranchTaken=1, Rt=5=Rs) -> IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1, stall_cycles unchanged.
- Multiply with MUL_LATENCY=4: IsMul=1 -> mul_start pulse at cycle 0; PCWrite=0 at cycles 0-2; mul_busy at cycles 1-3; enables 1 at cycle 3; RUN at cycle 4; stall_cycles=3.
- Reset asserted at the second MUL_WAIT cycle -> next edge: RUN, mul_busy=0, stall_cycles=0, no mul_start.
- Saturation with CNT_W=4: hold a load-use stall for 20 cycles -> stall_cycles stops at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Holds the controller state encoding, the hardwired-zero register index and the wait-counter width.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } ctrlState_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Wide enough for MUL_LATENCY-2 with MUL_LATENCY up to 16.
    localparam int CNT_BITS = 4;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: flags an ID-stage source that the load in EX has not yet written.
// Purely combinational; a load to $0 never creates a hazard.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       memRead,
    input  logic [4:0] exRt,
    input  logic [4:0] idRs,
    input  logic [4:0] idRt,
    output logic       hazard
);

    always_comb begin
        hazard = memRead && (exRt != REG_ZERO) && ((exRt == idRs) || (exRt == idRt));
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and multiply freezes.
// Also keeps a saturating count of cycles in which the PC was held.
module hazard_control_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_RegisterRt,
    input  logic             ID_EX_IsMul,
    input  logic [4:0]       IF_ID_RegisterRs,
    input  logic [4:0]       IF_ID_RegisterRt,
    input  logic             EX_BranchTaken,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             EX_MEM_Bubble,
    output logic             mul_start,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    // Loading MUL_LATENCY-2 makes the freeze last MUL_LATENCY-1 cycles, the last wait cycle releasing it.
    localparam logic [CNT_BITS-1:0] MUL_WAIT_INIT =
        (MUL_LATENCY > 1) ? CNT_BITS'(MUL_LATENCY - 2) : '0;
    localparam bit MUL_STALLS = (MUL_LATENCY > 1);

    ctrlState_e            state;
    ctrlState_e            stateNext;
    logic [CNT_BITS-1:0]   cnt;
    logic [CNT_BITS-1:0]   cntNext;
    logic                  loadUseHazard;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] val);
        return (val == {CNT_W{1'b1}}) ? val : val + 1'b1;
    endfunction

    load_use_detect uLoadUse (
        .memRead (ID_EX_MemRead),
        .exRt    (ID_EX_RegisterRt),
        .idRs    (IF_ID_RegisterRs),
        .idRt    (IF_ID_RegisterRt),
        .hazard  (loadUseHazard)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            cnt          <= '0;
            stall_cycles <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (!PCWrite) begin
                stall_cycles <= satInc(stall_cycles);
            end
        end
    end

    always_comb begin
        stateNext     = state;
        cntNext       = cnt;
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EX_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Bubble  = 1'b0;
        EX_MEM_Bubble = 1'b0;
        mul_start     = 1'b0;
        mul_busy      = 1'b0;

        if (!reset) begin
            unique case (state)
                RUN: begin
                    // A taken branch squashes the younger instructions, so any stall is moot.
                    if (EX_BranchTaken) begin
                        IF_ID_Flush  = 1'b1;
                        ID_EX_Bubble = 1'b1;
                    end else if (ID_EX_IsMul) begin
                        mul_start = 1'b1;
                        if (MUL_STALLS) begin
                            PCWrite       = 1'b0;
                            IF_ID_Write   = 1'b0;
                            ID_EX_Write   = 1'b0;
                            EX_MEM_Bubble = 1'b1;
                            stateNext     = MUL_WAIT;
                            cntNext       = MUL_WAIT_INIT;
                        end
                    end else if (loadUseHazard) begin
                        PCWrite      = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Bubble = 1'b1;
                    end
                end
                MUL_WAIT: begin
                    mul_busy = 1'b1;
                    if (cnt != '0) begin
                        PCWrite       = 1'b0;
                        IF_ID_Write   = 1'b0;
                        ID_EX_Write   = 1'b0;
                        EX_MEM_Bubble = 1'b1;
                        cntNext       = cnt - 1'b1;
                    end else begin
                        stateNext = RUN;
                    end
                end
                default: begin
                    stateNext = RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: a default instance plus a MUL_LATENCY=1, CNT_W=4 instance.
// Flags are packed {PCWrite,IF_ID_Write,ID_EX_Write,IF_ID_Flush,ID_EX_Bubble,EX_MEM_Bubble,mul_start,mul_busy}.
module tb_hazard_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        memRead;
    logic [4:0]  exRt;
    logic        isMul;
    logic [4:0]  idRs;
    logic [4:0]  idRt;
    logic        branchTaken;

    logic        aPcWrite, aIfIdWrite, aIdExWrite, aIfIdFlush, aIdExBubble, aExMemBubble, aMulStart, aMulBusy;
    logic [15:0] aStall;
    logic        bPcWrite, bIfIdWrite, bIdExWrite, bIfIdFlush, bIdExBubble, bExMemBubble, bMulStart, bMulBusy;
    logic [3:0]  bStall;

    int errCount = 0;
    int chkCount = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(.MUL_LATENCY(4), .CNT_W(16)) dutA (
        .clk(clk), .reset(reset),
        .ID_EX_MemRead(memRead), .ID_EX_RegisterRt(exRt), .ID_EX_IsMul(isMul),
        .IF_ID_RegisterRs(idRs), .IF_ID_RegisterRt(idRt), .EX_BranchTaken(branchTaken),
        .PCWrite(aPcWrite), .IF_ID_Write(aIfIdWrite), .ID_EX_Write(aIdExWrite),
        .IF_ID_Flush(aIfIdFlush), .ID_EX_Bubble(aIdExBubble), .EX_MEM_Bubble(aExMemBubble),
        .mul_start(aMulStart), .mul_busy(aMulBusy), .stall_cycles(aStall)
    );

    hazard_control_unit #(.MUL_LATENCY(1), .CNT_W(4)) dutB (
        .clk(clk), .reset(reset),
        .ID_EX_MemRead(memRead), .ID_EX_RegisterRt(exRt), .ID_EX_IsMul(isMul),
        .IF_ID_RegisterRs(idRs), .IF_ID_RegisterRt(idRt), .EX_BranchTaken(branchTaken),
        .PCWrite(bPcWrite), .IF_ID_Write(bIfIdWrite), .ID_EX_Write(bIdExWrite),
        .IF_ID_Flush(bIfIdFlush), .ID_EX_Bubble(bIdExBubble), .EX_MEM_Bubble(bExMemBubble),
        .mul_start(bMulStart), .mul_busy(bMulBusy), .stall_cycles(bStall)
    );

    wire [7:0] aFlags = {aPcWrite, aIfIdWrite, aIdExWrite, aIfIdFlush, aIdExBubble, aExMemBubble, aMulStart, aMulBusy};
    wire [7:0] bFlags = {bPcWrite, bIfIdWrite, bIdExWrite, bIfIdFlush, bIdExBubble, bExMemBubble, bMulStart, bMulBusy};

    localparam logic [7:0] F_IDLE   = 8'hE0;
    localparam logic [7:0] F_LDUSE  = 8'h28;
    localparam logic [7:0] F_BRANCH = 8'hF8;
    localparam logic [7:0] F_MULGO  = 8'h06;
    localparam logic [7:0] F_MULFRZ = 8'h05;
    localparam logic [7:0] F_MULEND = 8'hE1;
    localparam logic [7:0] F_MUL1   = 8'hE2;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        memRead = 1'b0; exRt = 5'd0; isMul = 1'b0;
        idRs = 5'd0; idRt = 5'd0; branchTaken = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clearInputs();
        repeat (2) nextCycle();
        checkVal("resetFlagsA", aFlags, F_IDLE);
        checkVal("resetStallA", aStall, 0);
        checkVal("resetStallB", bStall, 0);
        reset = 1'b0;
        #1;
        checkVal("idleFlagsA", aFlags, F_IDLE);

        // Load-use on Rs: one stall cycle
        memRead = 1'b1; exRt = 5'd5; idRs = 5'd5; idRt = 5'd9;
        #1;
        checkVal("loadUseRsA", aFlags, F_LDUSE);
        nextCycle();
        clearInputs();
        #1;
        checkVal("loadUseCntA", aStall, 1);
        checkVal("loadUseCntB", bStall, 1);
        checkVal("afterLoadUseA", aFlags, F_IDLE);

        // Load into $0 is never a hazard
        memRead = 1'b1; exRt = 5'd0; idRs = 5'd0; idRt = 5'd0;
        #1;
        checkVal("loadZeroA", aFlags, F_IDLE);
        // Load with no matching source
        exRt = 5'd7; idRs = 5'd3; idRt = 5'd4;
        #1;
        checkVal("noMatchA", aFlags, F_IDLE);
        nextCycle();
        checkVal("noStallCntA", aStall, 1);

        // Taken branch suppresses a concurrent load-use
        memRead = 1'b1; exRt = 5'd5; idRs = 5'd5; branchTaken = 1'b1;
        #1;
        checkVal("branchLdA", aFlags, F_BRANCH);
        nextCycle();
        checkVal("branchCntA", aStall, 1);

        // Branch wins over multiply; no wait state follows
        clearInputs();
        branchTaken = 1'b1; isMul = 1'b1;
        #1;
        checkVal("branchMulA", aFlags, F_BRANCH);
        nextCycle();
        clearInputs();
        #1;
        checkVal("branchMulNextA", aFlags, F_IDLE);

        // Multiply, latency 4 on A and latency 1 on B
        isMul = 1'b1;
        #1;
        checkVal("mulC0A", aFlags, F_MULGO);
        checkVal("mulC0B", bFlags, F_MUL1);
        nextCycle();
        isMul = 1'b0;
        #1;
        checkVal("mulC1A", aFlags, F_MULFRZ);
        checkVal("mulC1B", bFlags, F_IDLE);
        nextCycle();
        checkVal("mulC2A", aFlags, F_MULFRZ);
        nextCycle();
        checkVal("mulC3A", aFlags, F_MULEND);
        nextCycle();
        checkVal("mulC4A", aFlags, F_IDLE);
        checkVal("mulCntA", aStall, 4);
        checkVal("mulCntB", bStall, 1);

        // Reset in the second MUL_WAIT cycle abandons the multiply
        isMul = 1'b1;
        #1;
        nextCycle();
        isMul = 1'b0;
        nextCycle();
        checkVal("mulWait2A", aFlags, F_MULFRZ);
        reset = 1'b1;
        #1;
        checkVal("rstForceA", aFlags, F_IDLE);
        nextCycle();
        reset = 1'b0;
        #1;
        checkVal("rstRunA", aFlags, F_IDLE);
        checkVal("rstCntA", aStall, 0);
        checkVal("rstCntB", bStall, 0);
        nextCycle();
        checkVal("rstHoldA", aFlags, F_IDLE);

        // Held load-use via Rt: A counts to 20, B saturates at 15
        memRead = 1'b1; exRt = 5'd7; idRs = 5'd2; idRt = 5'd7;
        #1;
        checkVal("loadUseRtA", aFlags, F_LDUSE);
        repeat (20) nextCycle();
        checkVal("satCntA", aStall, 20);
        checkVal("satCntB", bStall, 15);
        nextCycle();
        checkVal("satHoldB", bStall, 15);
        clearInputs();

        $display("Result: errors=%0d of %0d checks", errCount, chkCount);
        $finish;
    end

endmodule
